// File: rtl/cdc_hs_src_ctrl_if.sv
// Handshake bundle between the local source, the source controller and the
// destination-domain REQ/ACK wires. Signal suffixes are from the controller's view.
interface cdc_hs_src_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  src_valid_i;
    logic [DATA_WIDTH-1:0] src_data_i;
    logic                  src_ready_o;
    logic                  ack_sync_i;
    logic                  err_clr_i;
    logic                  req_out_o;
    logic [DATA_WIDTH-1:0] data_out_o;
    logic                  busy_o;
    logic                  xfer_done_o;
    logic                  timeout_err_o;

    modport slave (
        input  src_valid_i, src_data_i, ack_sync_i, err_clr_i,
        output src_ready_o, req_out_o, data_out_o, busy_o, xfer_done_o, timeout_err_o
    );

    modport master (
        output src_valid_i, src_data_i, ack_sync_i, err_clr_i,
        input  src_ready_o, req_out_o, data_out_o, busy_o, xfer_done_o, timeout_err_o
    );
endinterface

// File: rtl/cdc_hs_src_ctrl.sv
// Source-side controller for a 4-phase REQ/ACK clock-domain crossing, with
// per-phase ACK timeout, sticky error flag and a guarded clear path.
module cdc_hs_src_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk_i,
    input logic                rst_i,
    cdc_hs_src_ctrl_if.slave   bus
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        ERR
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  req_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  err_q;
    logic                  timeout_hit;

    // A zero limit parameter disables timeout entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

    // A stale high ACK from a previous transfer must be gone before accepting.
    assign bus.src_ready_o   = (state_q == IDLE) && !bus.ack_sync_i;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.req_out_o     = req_q;
    assign bus.data_out_o    = data_q;
    assign bus.xfer_done_o   = done_q;
    assign bus.timeout_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.src_valid_i && !bus.ack_sync_i) begin
                        data_q  <= bus.src_data_i;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    // An arriving ACK takes priority over a coincident timeout.
                    if (bus.ack_sync_i) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= REQ_LO;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                REQ_LO: begin
                    if (!bus.ack_sync_i) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ERR: begin
                    req_q <= 1'b0;
                    if (bus.err_clr_i && !bus.ack_sync_i) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Scoreboard bench for cdc_hs_src_ctrl: accepted words are queued at the driver
// and popped against DATA_OUT whenever XFER_DONE pulses.
module tb_cdc_hs_src_ctrl;

    logic clk;
    logic rst;
    logic [2:0] reqHist;
    bit autoAck;
    logic [7:0] expQ[$];
    int nChecks;
    int nFails;

    cdc_hs_src_ctrl_if #(.DATA_WIDTH(8)) bus ();

    cdc_hs_src_ctrl #(
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: record acceptance at the edge, then model the destination ACK
    // which follows REQ_OUT two cycles late when autoAck is set.
    task automatic tick(output logic acc);
        logic [7:0] word;
        acc  = (!rst) && (bus.src_valid_i === 1'b1) && (bus.src_ready_o === 1'b1);
        word = bus.src_data_i;
        @(posedge clk);
        #1;
        if (acc) expQ.push_back(word);
        reqHist = {reqHist[1:0], bus.req_out_o};
        if (autoAck) bus.ack_sync_i = reqHist[2];
    endtask

    task automatic test_reset();
        logic acc;
        $display("[TB] test_reset");
        rst = 1'b1;
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = 8'hFF;
        tick(acc);
        tick(acc);
        nChecks++; if (bus.req_out_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %b expected 0", bus.req_out_o); end
        nChecks++; if (bus.data_out_o !== 8'h00) begin nFails++; $display("[TB] FAIL reset_data: got %h expected 00", bus.data_out_o); end
        nChecks++; if (bus.busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
        nChecks++; if (bus.timeout_err_o !== 1'b0 || bus.xfer_done_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: got err=%b done=%b expected 0/0", bus.timeout_err_o, bus.xfer_done_o); end
        bus.src_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        nChecks++; if (bus.src_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.src_ready_o); end
    endtask

    task automatic test_normal();
        logic acc;
        logic [7:0] exp;
        int doneCnt;
        int doneAt;
        $display("[TB] test_normal");
        autoAck = 1'b1;
        reqHist = '0;
        doneCnt = 0;
        doneAt  = -1;
        bus.src_data_i  = 8'hA5;
        bus.src_valid_i = 1'b1;
        tick(acc);
        bus.src_valid_i = 1'b0;
        nChecks++; if (acc !== 1'b1 || bus.req_out_o !== 1'b1) begin nFails++; $display("[TB] FAIL normal_accept: got acc=%b req=%b expected 1/1", acc, bus.req_out_o); end
        for (int i = 1; i <= 10; i++) begin
            tick(acc);
            if (bus.req_out_o === 1'b1) begin
                nChecks++; if (bus.data_out_o !== 8'hA5) begin nFails++; $display("[TB] FAIL normal_stable: got %h expected a5", bus.data_out_o); end
            end
            if (i == 3) begin
                nChecks++; if (bus.req_out_o !== 1'b0) begin nFails++; $display("[TB] FAIL normal_req_drop: got %b expected 0", bus.req_out_o); end
            end
            if (bus.xfer_done_o === 1'b1) begin
                doneCnt++;
                doneAt = i;
                nChecks++;
                if (expQ.size() == 0) begin nFails++; $display("[TB] FAIL normal_scoreboard: got done with empty queue expected a5"); end
                else begin
                    exp = expQ.pop_front();
                    if (bus.data_out_o !== exp) begin nFails++; $display("[TB] FAIL normal_data: got %h expected %h", bus.data_out_o, exp); end
                end
            end
        end
        nChecks++; if (doneCnt != 1) begin nFails++; $display("[TB] FAIL normal_done_count: got %0d expected 1", doneCnt); end
        nChecks++; if (doneAt != 6) begin nFails++; $display("[TB] FAIL normal_done_latency: got %0d expected 6", doneAt); end
        nChecks++; if (bus.src_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL normal_idle: got ready=%b busy=%b expected 1/0", bus.src_ready_o, bus.busy_o); end
        nChecks++; if (bus.data_out_o !== 8'hA5) begin nFails++; $display("[TB] FAIL normal_hold: got %h expected a5", bus.data_out_o); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [7:0] exp;
        logic [7:0] words [3];
        int idx;
        int doneCnt;
        $display("[TB] test_back_to_back");
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        autoAck = 1'b1;
        reqHist = '0;
        idx = 0;
        doneCnt = 0;
        bus.src_data_i  = words[0];
        bus.src_valid_i = 1'b1;
        for (int i = 0; i < 60 && doneCnt < 3; i++) begin
            tick(acc);
            if (acc) begin
                nChecks++; if (bus.data_out_o !== words[idx]) begin nFails++; $display("[TB] FAIL b2b_capture: got %h expected %h", bus.data_out_o, words[idx]); end
                idx++;
                if (idx < 3) bus.src_data_i = words[idx];
                else bus.src_valid_i = 1'b0;
            end
            if (bus.xfer_done_o === 1'b1) begin
                doneCnt++;
                nChecks++;
                if (expQ.size() == 0) begin nFails++; $display("[TB] FAIL b2b_scoreboard: got done with empty queue expected a word"); end
                else begin
                    exp = expQ.pop_front();
                    if (bus.data_out_o !== exp) begin nFails++; $display("[TB] FAIL b2b_data: got %h expected %h", bus.data_out_o, exp); end
                end
            end
        end
        bus.src_valid_i = 1'b0;
        nChecks++; if (doneCnt != 3) begin nFails++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneCnt); end
        nChecks++; if (idx != 3 || expQ.size() != 0) begin nFails++; $display("[TB] FAIL b2b_accepts: got accepted=%0d pending=%0d expected 3/0", idx, expQ.size()); end
    endtask

    task automatic test_timeout();
        logic acc;
        $display("[TB] test_timeout");
        autoAck = 1'b0;
        bus.ack_sync_i  = 1'b0;
        bus.src_data_i  = 8'h3C;
        bus.src_valid_i = 1'b1;
        tick(acc);
        bus.src_valid_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(acc);
            nChecks++; if (bus.req_out_o !== 1'b1 || bus.timeout_err_o !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_wait%0d: got req=%b err=%b expected 1/0", i, bus.req_out_o, bus.timeout_err_o); end
        end
        tick(acc);
        nChecks++; if (bus.req_out_o !== 1'b0 || bus.timeout_err_o !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_enter: got req=%b err=%b expected 0/1", bus.req_out_o, bus.timeout_err_o); end
        nChecks++; if (bus.busy_o !== 1'b1 || bus.src_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_state: got busy=%b ready=%b expected 1/0", bus.busy_o, bus.src_ready_o); end
        expQ.delete();
        tick(acc);
        tick(acc);
        nChecks++; if (bus.timeout_err_o !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_sticky: got %b expected 1", bus.timeout_err_o); end
        bus.err_clr_i = 1'b1;
        tick(acc);
        bus.err_clr_i = 1'b0;
        nChecks++; if (bus.timeout_err_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.src_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_clear: got err=%b busy=%b ready=%b expected 0/0/1", bus.timeout_err_o, bus.busy_o, bus.src_ready_o); end
        nChecks++; if (bus.data_out_o !== 8'h3C) begin nFails++; $display("[TB] FAIL timeout_hold: got %h expected 3c", bus.data_out_o); end
    endtask

    task automatic test_ack_timeout_race();
        logic acc;
        logic [7:0] exp;
        $display("[TB] test_ack_timeout_race");
        autoAck = 1'b0;
        bus.ack_sync_i  = 1'b0;
        bus.src_data_i  = 8'h77;
        bus.src_valid_i = 1'b1;
        tick(acc);
        bus.src_valid_i = 1'b0;
        tick(acc);
        tick(acc);
        tick(acc);
        bus.ack_sync_i = 1'b1;
        tick(acc);
        nChecks++; if (bus.timeout_err_o !== 1'b0 || bus.req_out_o !== 1'b0 || bus.busy_o !== 1'b1) begin nFails++; $display("[TB] FAIL race_ack_wins: got err=%b req=%b busy=%b expected 0/0/1", bus.timeout_err_o, bus.req_out_o, bus.busy_o); end
        bus.ack_sync_i = 1'b0;
        tick(acc);
        nChecks++;
        if (bus.xfer_done_o !== 1'b1) begin nFails++; $display("[TB] FAIL race_done: got %b expected 1", bus.xfer_done_o); end
        else if (expQ.size() == 0) begin nFails++; $display("[TB] FAIL race_scoreboard: got done with empty queue expected 77"); end
        else begin
            exp = expQ.pop_front();
            if (bus.data_out_o !== exp) begin nFails++; $display("[TB] FAIL race_data: got %h expected %h", bus.data_out_o, exp); end
        end
        tick(acc);
        nChecks++; if (bus.xfer_done_o !== 1'b0) begin nFails++; $display("[TB] FAIL race_done_pulse: got %b expected 0", bus.xfer_done_o); end
    endtask

    task automatic test_err_clr_blocked();
        logic acc;
        $display("[TB] test_err_clr_blocked");
        autoAck = 1'b0;
        bus.ack_sync_i  = 1'b0;
        bus.src_data_i  = 8'h11;
        bus.src_valid_i = 1'b1;
        tick(acc);
        bus.src_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        expQ.delete();
        nChecks++; if (bus.timeout_err_o !== 1'b1) begin nFails++; $display("[TB] FAIL blocked_enter: got %b expected 1", bus.timeout_err_o); end
        bus.ack_sync_i = 1'b1;
        bus.err_clr_i  = 1'b1;
        tick(acc);
        nChecks++; if (bus.timeout_err_o !== 1'b1 || bus.busy_o !== 1'b1) begin nFails++; $display("[TB] FAIL blocked_clr_ignored: got err=%b busy=%b expected 1/1", bus.timeout_err_o, bus.busy_o); end
        bus.err_clr_i  = 1'b0;
        bus.ack_sync_i = 1'b0;
        tick(acc);
        nChecks++; if (bus.timeout_err_o !== 1'b1) begin nFails++; $display("[TB] FAIL blocked_no_clr: got %b expected 1", bus.timeout_err_o); end
        bus.err_clr_i = 1'b1;
        tick(acc);
        bus.err_clr_i = 1'b0;
        nChecks++; if (bus.timeout_err_o !== 1'b0 || bus.busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL blocked_clear: got err=%b busy=%b expected 0/0", bus.timeout_err_o, bus.busy_o); end
    endtask

    task automatic test_mid_reset();
        logic acc;
        $display("[TB] test_mid_reset");
        autoAck = 1'b0;
        bus.ack_sync_i  = 1'b0;
        bus.src_data_i  = 8'h5A;
        bus.src_valid_i = 1'b1;
        tick(acc);
        bus.src_valid_i = 1'b0;
        bus.ack_sync_i  = 1'b1;
        tick(acc);
        nChecks++; if (bus.req_out_o !== 1'b0 || bus.busy_o !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_reqlo: got req=%b busy=%b expected 0/1", bus.req_out_o, bus.busy_o); end
        rst = 1'b1;
        tick(acc);
        nChecks++; if (bus.busy_o !== 1'b0 || bus.data_out_o !== 8'h00 || bus.req_out_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_state: got busy=%b data=%h req=%b expected 0/00/0", bus.busy_o, bus.data_out_o, bus.req_out_o); end
        rst = 1'b0;
        tick(acc);
        nChecks++; if (bus.xfer_done_o !== 1'b0 || bus.src_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_stale_ack: got done=%b ready=%b expected 0/0", bus.xfer_done_o, bus.src_ready_o); end
        bus.ack_sync_i = 1'b0;
        #1;
        nChecks++; if (bus.src_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_ready: got %b expected 1", bus.src_ready_o); end
        expQ.delete();
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        autoAck = 1'b0;
        reqHist = '0;
        rst = 1'b1;
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 8'h00;
        bus.ack_sync_i  = 1'b0;
        bus.err_clr_i   = 1'b0;
        test_reset();
        test_normal();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_race();
        test_err_clr_blocked();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
